// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcode map, immediate formats, ex_ctrl layout
// and the per-opcode operand-usage table.
package decode_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // ex_ctrl = {insn[6:2], funct3, insn[30]}
  localparam int CTRL_W       = 9;
  localparam int CTRL_OPC_LSB = 4;
  localparam int CTRL_F3_LSB  = 1;
  localparam int CTRL_ALT_BIT = 0;

  typedef struct packed {
    logic     use_rs1;
    logic     use_rs2;
    logic     use_rd;
    logic     legal;
    imm_fmt_e fmt;
  } dec_info_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       op1;
    logic [31:0]       op2;
    logic [31:0]       imm;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } ex_bundle_t;

  function automatic dec_info_t decode_opc(input logic [4:0] opc);
    dec_info_t d;
    d = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b0, legal: 1'b1, fmt: IMM_NONE};
    case (opc)
      OPC_LUI:      begin d.use_rd = 1'b1; d.fmt = IMM_U; end
      OPC_AUIPC:    begin d.use_rd = 1'b1; d.fmt = IMM_U; end
      OPC_JAL:      begin d.use_rd = 1'b1; d.fmt = IMM_J; end
      OPC_JALR:     begin d.use_rs1 = 1'b1; d.use_rd = 1'b1; d.fmt = IMM_I; end
      OPC_BRANCH:   begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.fmt = IMM_B; end
      OPC_LOAD:     begin d.use_rs1 = 1'b1; d.use_rd = 1'b1; d.fmt = IMM_I; end
      OPC_STORE:    begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.fmt = IMM_S; end
      OPC_OP_IMM:   begin d.use_rs1 = 1'b1; d.use_rd = 1'b1; d.fmt = IMM_I; end
      OPC_OP:       begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.use_rd = 1'b1; end
      OPC_MISC_MEM: d.fmt = IMM_I;
      OPC_SYSTEM:   begin d.use_rd = 1'b1; d.fmt = IMM_I; end
      default:      d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction; opcode bits are not needed since the
// format is chosen by the caller.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] i_insn,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I:   o_imm = {{20{i_insn[31]}}, i_insn[31:20]};
      IMM_S:   o_imm = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
      IMM_B:   o_imm = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25],
                        i_insn[11:8], 1'b0};
      IMM_U:   o_imm = {i_insn[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20],
                        i_insn[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry decode slot, one-entry execute slot, register
// scoreboard. Define RV32E_EN to restrict to x0..x15 (higher indices illegal).
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_insn,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  input  logic [31:0]       rdata1,
  input  logic [31:0]       rdata2,
  input  logic              wen,
  input  logic [4:0]        wreg,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_illegal
);

`ifdef RV32E_EN
  localparam logic [31:0] SB_MASK = 32'h0000_FFFE;
`else
  localparam logic [31:0] SB_MASK = 32'hFFFF_FFFE;
`endif

  logic        r_d_valid;
  logic [31:0] r_pc;
  logic [31:0] r_insn;
  logic        r_ex_valid;
  ex_bundle_t  r_ex;
  logic [31:0] r_sb;

  dec_info_t   w_info;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_ext_bad;
  logic        w_illegal;
  logic        w_use_rs1, w_use_rs2, w_use_rd;
  logic        w_haz1, w_haz2;
  logic        w_issue;
  imm_fmt_e    w_fmt;
  logic [31:0] w_imm;
  ex_bundle_t  w_ex_nxt;
  logic [31:0] w_set_mask, w_clr_mask;

  assign w_info = decode_opc(r_insn[6:2]);
  assign w_rs1  = r_insn[19:15];
  assign w_rs2  = r_insn[24:20];
  assign w_rd   = r_insn[11:7];

`ifdef RV32E_EN
  assign w_ext_bad = (w_info.use_rs1 & w_rs1[4]) | (w_info.use_rs2 & w_rs2[4]) |
                     (w_info.use_rd & w_rd[4]);
`else
  assign w_ext_bad = 1'b0;
`endif

  // Illegal instructions carry no sources or destination, so never stall.
  assign w_illegal = (r_insn[1:0] != 2'b11) | ~w_info.legal | w_ext_bad;
  assign w_use_rs1 = w_info.use_rs1 & ~w_illegal;
  assign w_use_rs2 = w_info.use_rs2 & ~w_illegal;
  assign w_use_rd  = w_info.use_rd & ~w_illegal;

  // A same-cycle writeback clears the pending bit early; the regfile
  // passthrough supplies the data.
  assign w_haz1 = w_use_rs1 & (w_rs1 != 5'd0) &
                  ((r_sb[w_rs1] & ~(wen & (wreg == w_rs1))) |
                   (r_ex_valid & (r_ex.rd == w_rs1)));
  assign w_haz2 = w_use_rs2 & (w_rs2 != 5'd0) &
                  ((r_sb[w_rs2] & ~(wen & (wreg == w_rs2))) |
                   (r_ex_valid & (r_ex.rd == w_rs2)));

  assign w_issue  = r_d_valid & ~(w_haz1 | w_haz2) & ~flush & (~r_ex_valid | ex_ready);
  assign if_ready = ~flush & (~r_d_valid | w_issue);

  assign rs1 = w_rs1;
  assign rs2 = w_rs2;

  assign w_fmt = w_illegal ? IMM_NONE : w_info.fmt;

  imm_gen u_imm_gen (
    .i_insn (r_insn[31:7]),
    .i_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  always_comb begin
    w_ex_nxt                              = '0;
    w_ex_nxt.pc                           = r_pc;
    w_ex_nxt.op1                          = w_use_rs1 ? rdata1 : 32'd0;
    w_ex_nxt.op2                          = w_use_rs2 ? rdata2 : 32'd0;
    w_ex_nxt.imm                          = w_imm;
    w_ex_nxt.rd                           = w_use_rd ? w_rd : 5'd0;
    w_ex_nxt.ctrl[CTRL_OPC_LSB +: 5]      = r_insn[6:2];
    w_ex_nxt.ctrl[CTRL_F3_LSB +: 3]       = r_insn[14:12];
    w_ex_nxt.ctrl[CTRL_ALT_BIT]           = r_insn[30];
    w_ex_nxt.illegal                      = w_illegal;
  end

  // Set on execute handshake wins over a same-register writeback clear.
  assign w_set_mask = (r_ex_valid & ex_ready & ~flush & (r_ex.rd != 5'd0)) ?
                      (32'd1 << r_ex.rd) : 32'd0;
  assign w_clr_mask = (wen & (wreg != 5'd0)) ? (32'd1 << wreg) : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_d_valid  <= 1'b0;
      r_pc       <= '0;
      r_insn     <= '0;
      r_ex_valid <= 1'b0;
      r_ex       <= '0;
      r_sb       <= '0;
    end else begin
      if (flush)
        r_d_valid <= 1'b0;
      else if (if_valid && if_ready) begin
        r_d_valid <= 1'b1;
        r_pc      <= if_pc;
        r_insn    <= if_insn;
      end else if (w_issue)
        r_d_valid <= 1'b0;

      if (flush)
        r_ex_valid <= 1'b0;
      else if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex       <= w_ex_nxt;
      end else if (ex_ready)
        r_ex_valid <= 1'b0;

      r_sb <= ((r_sb & ~w_clr_mask) | w_set_mask) & SB_MASK;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_pc      = r_ex.pc;
  assign ex_op1     = r_ex.op1;
  assign ex_op2     = r_ex.op2;
  assign ex_imm     = r_ex.imm;
  assign ex_rd      = r_ex.rd;
  assign ex_ctrl    = r_ex.ctrl;
  assign ex_illegal = r_ex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, expected bundles
// queued at issue time and compared by a monitor on each execute handshake.
module tb_decode_stage;

  logic        clk, reset_n;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_insn;
  logic [4:0]  rs1, rs2;
  logic [31:0] rdata1, rdata2;
  logic        wen;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [8:0]  ex_ctrl;
  logic        ex_illegal;

  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          n_cmp, n_bad;
  logic [31:0] regs [32];

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_insn(if_insn), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .wen(wen), .wreg(wreg), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small regfile with same-cycle write passthrough; x2 preloaded with 7.
  always_comb begin
    rdata1 = (rs1 == 5'd0) ? 32'd0 : (wen && wreg == rs1) ? wdata : regs[rs1];
    rdata2 = (rs2 == 5'd0) ? 32'd0 : (wen && wreg == rs2) ? wdata : regs[rs2];
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 2) ? 32'd7 : 32'd0;
    end else if (wen && wreg != 5'd0) regs[wreg] <= wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [31:0] pc, op1, op2, imm,
                              input logic [4:0] rd, input logic [8:0] ctrl,
                              input logic ill);
    exp_t e;
    e = '{pc: pc, op1: op1, op2: op2, imm: imm, rd: rd, ctrl: ctrl, ill: ill};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (reset_n && ex_valid && ex_ready) begin
        g = mk(ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_ctrl, ex_illegal);
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_bundle: got pc %h, expected no bundle", ex_pc);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL bundle pc=%h: got op1 %h op2 %h imm %h rd %0d ctrl %h ill %b pc %h expected op1 %h op2 %h imm %h rd %0d ctrl %h ill %b pc %h",
                     e.pc, g.op1, g.op2, g.imm, g.rd, g.ctrl, g.ill, g.pc,
                     e.op1, e.op2, e.imm, e.rd, e.ctrl, e.ill, e.pc);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn);
    if_valid = v;
    if_pc    = pc;
    if_insn  = insn;
  endtask

  logic [31:0] b_insn [7];
  exp_t        b_exp  [7];

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; flush = 1'b0; wen = 1'b0; wreg = '0; wdata = '0;
    ex_ready = 1'b1;
    drive(1'b0, '0, '0);
    fork monitor(); join_none

    // reset state
    step(); step();
    @(negedge clk);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_imm", ex_imm, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_if_ready", if_ready, 1);
    step();

    // addi x1,x0,5 then add x3,x1,x2 stalled on x1
    drive(1'b1, 32'h100, 32'h00500093);
    q.push_back(mk(32'h100, 0, 0, 5, 5'd1, 9'h040, 1'b0));
    @(negedge clk); chk("addi_accept", if_ready, 1);
    step();
    drive(1'b1, 32'h104, 32'h002081B3);
    q.push_back(mk(32'h104, 5, 7, 0, 5'd3, 9'h0C0, 1'b0));
    @(negedge clk); chk("add_accept", if_ready, 1);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk); chk("addi_ex_valid", ex_valid, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("add_stall", ex_valid, 0);
      step();
    end
    wen = 1'b1; wreg = 5'd1; wdata = 32'd5;
    @(negedge clk); chk("add_stall_wb", ex_valid, 0);
    step();
    wen = 1'b0;
    @(negedge clk); chk("add_issue_on_wb", ex_valid, 1);
    step();
    wen = 1'b1; wreg = 5'd3; wdata = 32'h33;
    step();
    wen = 1'b0;
    step();

    // execute back-pressure for three cycles
    ex_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h00100213);
    q.push_back(mk(32'h200, 0, 0, 1, 5'd4, 9'h040, 1'b0));
    step();
    drive(1'b1, 32'h204, 32'h00200293);
    q.push_back(mk(32'h204, 0, 0, 2, 5'd5, 9'h040, 1'b0));
    step();
    drive(1'b1, 32'h208, 32'h00300313);
    q.push_back(mk(32'h208, 0, 0, 3, 5'd6, 9'h040, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ex_valid", ex_valid, 1);
      chk("bp_ex_pc", ex_pc, 32'h200);
      chk("bp_ex_imm", ex_imm, 1);
      chk("bp_ex_rd", ex_rd, 4);
      chk("bp_if_ready", if_ready, 0);
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk); chk("bp_release_if_ready", if_ready, 1);
    step();
    drive(1'b0, '0, '0);
    step(); step(); step();

    // flush with both slots full
    ex_ready = 1'b0;
    drive(1'b1, 32'h300, 32'h00700393);
    step();
    drive(1'b1, 32'h304, 32'h00800413);
    step();
    drive(1'b0, '0, '0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_ex_valid", ex_valid, 1);
    chk("flush_if_ready", if_ready, 0);
    step();
    flush = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_d_empty", if_ready, 1);
    step();
    drive(1'b1, 32'h308, 32'h00038493);
    q.push_back(mk(32'h308, 0, 0, 0, 5'd9, 9'h040, 1'b0));
    step();
    drive(1'b0, '0, '0);
    step();
    @(negedge clk); chk("flush_no_sb_set", ex_valid, 1);
    step(); step();

    // back-to-back immediates and illegal encodings
    b_insn[0] = 32'hFFFFF537; b_exp[0] = mk(32'h400, 0, 0, 32'hFFFFF000, 5'd10, 9'h0DF, 1'b0);
    b_insn[1] = 32'hFE202E23; b_exp[1] = mk(32'h404, 0, 7, 32'hFFFFFFFC, 5'd0, 9'h085, 1'b0);
    b_insn[2] = 32'hFE000CE3; b_exp[2] = mk(32'h408, 0, 0, 32'hFFFFFFF8, 5'd0, 9'h181, 1'b0);
    b_insn[3] = 32'h001005EF; b_exp[3] = mk(32'h40C, 0, 0, 32'h00000800, 5'd11, 9'h1B0, 1'b0);
    b_insn[4] = 32'hFFFFFFFF; b_exp[4] = mk(32'h410, 0, 0, 0, 5'd0, 9'h1FF, 1'b1);
    b_insn[5] = 32'h00000000; b_exp[5] = mk(32'h414, 0, 0, 0, 5'd0, 9'h000, 1'b1);
    b_insn[6] = 32'h00100813;
`ifdef RV32E_EN
    b_exp[6] = mk(32'h418, 0, 0, 0, 5'd0, 9'h040, 1'b1);
`else
    b_exp[6] = mk(32'h418, 0, 0, 1, 5'd16, 9'h040, 1'b0);
`endif
    for (int k = 0; k < 9; k++) begin
      if (k < 7) begin
        drive(1'b1, 32'h400 + 32'(4 * k), b_insn[k]);
        q.push_back(b_exp[k]);
      end else drive(1'b0, '0, '0);
      @(negedge clk);
      if (k < 7) chk("burst_if_ready", if_ready, 1);
      if (k >= 2) chk("burst_ex_valid", ex_valid, 1);
      step();
    end
    step();

    // reset mid-operation discards both slots and the scoreboard
    ex_ready = 1'b0;
    drive(1'b1, 32'h480, 32'h00100213);
    step();
    drive(1'b1, 32'h484, 32'h00100213);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk); chk("mid_rst_pre_ex_valid", ex_valid, 1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_ex_pc", ex_pc, 0);
    chk("mid_rst_if_ready", if_ready, 1);
    step();
    drive(1'b1, 32'h500, 32'h00020613);
    q.push_back(mk(32'h500, 0, 0, 0, 5'd12, 9'h040, 1'b0));
    step();
    drive(1'b0, '0, '0);
    step();
    @(negedge clk); chk("mid_rst_sb_cleared", ex_valid, 1);
    step(); step(); step();

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
